// File: rtl/traffic_controller.sv
// traffic_controller: highway/crossing signal sequencer driven by a crossing-road vehicle sensor
module traffic_controller #(
  parameter int HWY_MIN_GREEN   = 4,
  parameter int Y2R_CYCLES      = 3,
  parameter int R2G_CYCLES      = 2,
  parameter int CROSS_MAX_GREEN = 8
) (
  input  logic       sensor,
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] Light_Highway,
  output logic [1:0] Light_Crossing
);
  typedef enum logic [2:0] {
    HGRE_CRED  = 3'd0,
    HYEL_CRED  = 3'd1,
    HRED_CRED1 = 3'd2,
    HRED_CGRE  = 3'd3,
    HRED_CYEL  = 3'd4,
    HRED_CRED2 = 3'd5
  } state_t;
  localparam logic [1:0] RED = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] GRN = 2'b10;
  localparam logic [7:0] MIN_G_LAST = 8'(HWY_MIN_GREEN - 1);
  localparam logic [7:0] Y2R_LAST   = 8'(Y2R_CYCLES - 1);
  localparam logic [7:0] R2G_LAST   = 8'(R2G_CYCLES - 1);
  localparam logic [7:0] MAX_G_LAST = 8'(CROSS_MAX_GREEN - 1);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HGRE_CRED;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    case (state_q)
      HGRE_CRED: begin
        if (cnt_q >= MIN_G_LAST) begin
          state_d = sensor ? HYEL_CRED : HGRE_CRED;
          cnt_d   = MIN_G_LAST;
        end
      end
      HYEL_CRED:  state_d = (cnt_q == Y2R_LAST) ? HRED_CRED1 : HYEL_CRED;
      HRED_CRED1: state_d = (cnt_q == R2G_LAST) ? HRED_CGRE : HRED_CRED1;
      HRED_CGRE:  state_d = (!sensor || cnt_q == MAX_G_LAST) ? HRED_CYEL : HRED_CGRE;
      HRED_CYEL:  state_d = (cnt_q == Y2R_LAST) ? HRED_CRED2 : HRED_CYEL;
      HRED_CRED2: state_d = (cnt_q == R2G_LAST) ? HGRE_CRED : HRED_CRED2;
      default:    state_d = HGRE_CRED;
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
  end
  always_comb begin
    Light_Highway  = RED;
    Light_Crossing = RED;
    case (state_q)
      HGRE_CRED: Light_Highway  = GRN;
      HYEL_CRED: Light_Highway  = YEL;
      HRED_CGRE: Light_Crossing = GRN;
      HRED_CYEL: Light_Crossing = YEL;
      default: begin
        Light_Highway  = RED;
        Light_Crossing = RED;
      end
    endcase
  end
endmodule

// File: tb/tb_traffic_controller.sv
// tb_traffic_controller: directed sequences with a per-cycle expected-light scoreboard
module tb_traffic_controller;
  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor = 1'b0;
  logic [1:0] Light_Highway, Light_Crossing;
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc_no = 0;
  traffic_controller dut (
    .sensor        (sensor),
    .clk           (clk),
    .rst           (rst),
    .Light_Highway (Light_Highway),
    .Light_Crossing(Light_Crossing)
  );
  always #5 clk = ~clk;
  // Each entry is the pair of lights expected just after the next rising edge.
  task automatic cyc(input logic s, input logic [1:0] hw, input logic [1:0] cr);
    @(negedge clk);
    sensor = s;
    exp_q.push_back({hw, cr});
  endtask
  task automatic phase(input logic s, input logic [1:0] hw, input logic [1:0] cr, input int n);
    for (int i = 0; i < n; i++) cyc(s, hw, cr);
  endtask
  task automatic direct_check(input string name);
    checks++;
    if (Light_Highway !== G || Light_Crossing !== R) begin
      errors++;
      $display("FAIL %s: got hw=%b cr=%b, want hw=%b cr=%b", name, Light_Highway, Light_Crossing, G, R);
    end
  endtask
  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Light_Highway, Light_Crossing} !== e) begin
          errors++;
          $display("FAIL lights@cyc%0d: got hw=%b cr=%b, want hw=%b cr=%b",
                   cyc_no, Light_Highway, Light_Crossing, e[3:2], e[1:0]);
        end
      end
    end
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
    $fatal(1, "timeout");
  end
  initial begin : stim
    #2;
    direct_check("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({G, R});
    phase(0, G, R, 49);
    // Min green already met: sensor high gives yellow after one edge
    cyc(1, Y, R);
    cyc(1, Y, R); cyc(0, Y, R);
    cyc(1, R, R); cyc(0, R, R);
    cyc(1, R, G);
    phase(1, R, G, 2);
    // Early release at crossing-green cycle 3
    cyc(0, R, Y);
    cyc(1, R, Y); cyc(1, R, Y);
    cyc(1, R, R); cyc(0, R, R);
    cyc(1, G, R);
    // Continuous demand: full 22-cycle period with min/max green
    phase(1, G, R, 3);
    phase(1, Y, R, 3);
    phase(1, R, R, 2);
    phase(1, R, G, 8);
    phase(1, R, Y, 3);
    phase(1, R, R, 2);
    phase(1, G, R, 4);
    phase(1, Y, R, 3);
    phase(1, R, R, 2);
    phase(1, R, G, 8);
    phase(1, R, Y, 3);
    phase(1, R, R, 2);
    // Request pulse that ends during the yellow/red phases: one crossing-green cycle
    phase(1, G, R, 4);
    phase(1, Y, R, 3);
    phase(0, R, R, 2);
    cyc(0, R, G);
    cyc(0, R, Y);
    phase(1, R, Y, 2);
    phase(1, R, R, 2);
    cyc(0, G, R);
    phase(0, G, R, 5);
    // Walk into crossing green, then reset asynchronously mid-phase
    cyc(1, Y, R);
    phase(1, Y, R, 2);
    phase(1, R, R, 2);
    phase(1, R, G, 2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    direct_check("async_reset_mid_cross_green");
    @(posedge clk);
    #1;
    direct_check("reset_held");
    @(negedge clk);
    rst = 1'b0;
    // Counter restarts at zero: four green edges with demand, then yellow
    sensor = 1'b1;
    exp_q.push_back({G, R});
    phase(1, G, R, 2);
    cyc(1, Y, R);
    phase(0, Y, R, 2);
    phase(0, R, R, 2);
    cyc(0, R, G);
    cyc(0, R, Y);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending=%0d, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
